mem_bus_sequencer: RTL
======================

// Module: mem_bus_sequencer
// PURPOSE
//  Shares the single memory bus between the L1 miss/writeback requesters: dirty-line writeback,
//  data port 1 miss, data port 2 miss and instruction miss. Sequences each full 64 B line
//  transfer: address beat, then BEATS data beats out (write) or in (read).
//  Sits between the cache lookup logic and the top-level bus pins.
//  Returns the assembled line plus a one-cycle done to the granted requester.
// PARAMETERS
//  ADDR_W  64  byte address width (`ADDRESS_SIZE)
//  DATA_W  64  bus beat width (`BUS_DATA_WIDTH)
//  TAG_W   13  bus tag width (`BUS_TAG_WIDTH)
//  BEATS   8   beats per line; line bytes = BEATS*DATA_W/8 = 64
//  NREQ    4   requesters: 0=writeback, 1=data1, 2=data2, 3=instruction
// PORTS
//  clk        in   1               clock, single domain
//  reset      in   1               asynchronous, active-high
//  req        in   NREQ            per-requester request, level, held until done
//  req_addr   in   NREQ*ADDR_W     per-requester byte address (any alignment)
//  wb_line    in   BEATS*DATA_W    writeback line (requester 0 only; beat k = bits [k*DATA_W+:DATA_W])
//  grant      out  NREQ            one-hot owner of current transaction; 0 when idle
//  done       out  1               one-cycle pulse: transaction for grant complete
//  rd_line    out  BEATS*DATA_W    assembled read line, valid while done=1
//  bus_reqcyc out  1               request beat valid
//  bus_reqack in   1               bus accepted current request beat
//  bus_req    out  DATA_W          address beat or write data beat
//  bus_reqtag out  TAG_W           `MEM_READ or `MEM_WRITE
//  bus_respcyc in  1               response beat valid
//  bus_respack out 1               response beat acknowledge
//  bus_resp   in   DATA_W          response data
//  bus_resptag in  TAG_W           response tag
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; grant, done, bus_reqcyc, bus_respack = 0;
//   bus_req, bus_reqtag, rd_line, beat counter = 0. Transaction in flight is abandoned.
//  Arbitration in IDLE only; owner latched, never preempted:
//   - requester 0 (writeback) has absolute priority;
//   - 1..3 round-robin, starting after last granted read requester (after reset: 1).
//  Address beat = req_addr & ~(BEATS*DATA_W/8-1), i.e. low 6 bits cleared.
//  FSM:
//   IDLE    : any req -> latch owner/addr, grant=onehot, bus_reqcyc=1, bus_req=addr,
//             tag=`MEM_WRITE if owner 0 else `MEM_READ; -> ADDR (next cycle)
//   ADDR    : hold all bus_req* stable until bus_reqack sampled high;
//             then read -> RD_WAIT with reqcyc=0; write -> WR_DATA with beat 0 presented
//   WR_DATA : present wb_line beat k (latched at grant); advance on each reqack;
//             after beat BEATS-1 accepted -> DONE
//   RD_WAIT : on bus_respcyc && bus_resptag==`MEM_READ: store bus_resp into rd_line beat k,
//             k++, bus_respack=1 in the following cycle (one-cycle pulse per beat).
//             Beats with any other tag: ignored, not acked. After beat BEATS-1 -> DONE
//   DONE    : done=1 for exactly one cycle; grant stays asserted this cycle; -> IDLE
//             (grant=0). Re-arbitration takes place in that IDLE cycle.
//  Latency, zero-wait bus: read = 1 (ADDR) + BEATS + 1 (DONE) cycles min from grant.
//  Boundaries:
//   - req deasserted mid-transaction: transaction completes, done still pulses
//   - req_addr changes after grant: ignored (address latched)
//   - beat counter is log2(BEATS) bits, wraps to 0 exactly at DONE
//   - respcyc in IDLE/ADDR/WR_DATA: ignored, no respack
//   - back-to-back respcyc: each beat stored and acked; respack may stay high
//   - all NREQ requests at once: 0 first, then 1,2,3 in RR order
// STRUCTURE
//  Shared package: `MEM_READ/`MEM_WRITE tags, BEATS, requester index enum
//   (REQ_WB, REQ_D1, REQ_D2, REQ_I), seq_state_t enum.
//  Sub-module rr_arbiter (NREQ-1 inputs, rotating priority pointer) for requesters 1..3;
//   writeback priority override in this module.
// TESTING
//  1 req=4'b1000, addr 0x1234 -> bus_req=0x1200 tag MEM_READ; 8 resp beats 0..7 -> rd_line beat k=k, done 1 cycle
//  2 req=4'b1111, wb_line beats 0xA0..0xA7 -> writeback first: addr beat + 8 data beats 0xA0..0xA7 in order; then grants 2,4,8
//  3 bus_reqack held low 5 cycles in ADDR -> bus_req/tag/reqcyc unchanged for all 5 cycles
//  4 resp beat with tag!=MEM_READ during RD_WAIT -> not stored, no respack, beat count unchanged
//  5 reset asserted after beat 3 of read -> same-cycle grant=0, reqcyc=0; next req restarts at beat 0
//  6 req withdrawn after address accepted -> 8 beats still consumed, done pulses, then idle

Source files
------------

// File: rtl/mem_bus_sequencer_pkg.sv
// Shared types and constants for the L1 memory bus sequencer.
// Tags, line geometry, requester indices and sequencer state encoding.
package mem_bus_sequencer_pkg;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 13;
    localparam int BEATS      = 8;
    localparam int NREQ       = 4;
    localparam int LINE_BYTES = BEATS * DATA_W / 8;

    localparam logic [TAG_W-1:0] MEM_READ  = 13'b1_0001;
    localparam logic [TAG_W-1:0] MEM_WRITE = 13'b0_0001;

    typedef enum logic [1:0] {REQ_WB, REQ_D1, REQ_D2, REQ_I} req_idx_t;

    typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_WAIT, DONE} seq_state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// Top-level memory bus: request channel (cyc/ack/data/tag) and response channel.
interface mem_bus_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
);
    logic              reqcyc;
    logic              reqack;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              respcyc;
    logic              respack;
    logic [DATA_W-1:0] resp;
    logic [TAG_W-1:0]  resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/mem_bus_sequencer_rr_arbiter.sv
// Round-robin arbiter over N requesters; priority starts just after the last winner.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [IW-1:0] gnt_idx,
    output logic          valid
);
    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    // Reset pointer to the last slot so slot 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else if (advance && valid) begin
            last_q <= gnt_idx;
        end
    end

    always_comb begin
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_q) + i) % N);
            if (!valid && req[cand]) begin
                valid   = 1'b1;
                gnt_idx = cand;
            end
        end
    end
endmodule

// File: rtl/mem_bus_sequencer.sv
// Shares the memory bus between writeback and the three L1 miss requesters,
// sequencing one full-line transfer (address beat + BEATS data beats) per grant.
//   state   | meaning
//   IDLE    | no owner; arbitrate and launch the address beat
//   ADDR    | address beat held until reqack
//   WR_DATA | writeback beats presented, one per reqack
//   RD_WAIT | collecting MEM_READ response beats into rd_line
//   DONE    | done pulse to owner, grant released next cycle
module mem_bus_sequencer
    import mem_bus_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [BEATS*DATA_W-1:0] wb_line,
    output logic [NREQ-1:0]         grant,
    output logic                    done,
    output logic [BEATS*DATA_W-1:0] rd_line,
    mem_bus_sequencer_if.master     bus
);
    localparam int BW  = $clog2(BEATS);
    localparam int LW  = $clog2(BEATS * DATA_W);
    localparam int AIW = $clog2(NREQ * ADDR_W);

    seq_state_t              state_q, state_d;
    logic [NREQ-1:0]         grant_q, grant_d;
    logic                    done_q, done_d;
    logic [BEATS*DATA_W-1:0] rd_line_q, rd_line_d;
    logic [BEATS*DATA_W-1:0] wb_q, wb_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    reqcyc_q, reqcyc_d;
    logic                    respack_q, respack_d;
    logic [DATA_W-1:0]       req_q, req_d;
    logic [TAG_W-1:0]        tag_q, tag_d;

    logic [1:0]        rr_idx;
    logic              rr_valid;
    logic              rr_adv;
    req_idx_t          win;
    logic [ADDR_W-1:0] win_addr;
    logic              last_beat;
    logic [LW-1:0]     cur_base;
    logic [LW-1:0]     nxt_base;

    rr_arbiter #(.N(NREQ - 1)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req[NREQ-1:1]),
        .advance (rr_adv),
        .gnt_idx (rr_idx),
        .valid   (rr_valid)
    );

    // Writeback always wins; otherwise the rotating winner among 1..3.
    assign win       = req[REQ_WB] ? REQ_WB : req_idx_t'(rr_idx + 2'd1);
    assign win_addr  = req_addr[AIW'(win) * AIW'(ADDR_W) +: ADDR_W];
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign cur_base  = LW'(beat_q) * LW'(DATA_W);
    assign nxt_base  = LW'(beat_d) * LW'(DATA_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            done_q    <= 1'b0;
            rd_line_q <= '0;
            wb_q      <= '0;
            beat_q    <= '0;
            reqcyc_q  <= 1'b0;
            respack_q <= 1'b0;
            req_q     <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rd_line_q <= rd_line_d;
            wb_q      <= wb_d;
            beat_q    <= beat_d;
            reqcyc_q  <= reqcyc_d;
            respack_q <= respack_d;
            req_q     <= req_d;
            tag_q     <= tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        rd_line_d = rd_line_q;
        wb_d      = wb_q;
        beat_d    = beat_q;
        reqcyc_d  = reqcyc_q;
        respack_d = 1'b0;
        req_d     = req_q;
        tag_d     = tag_q;
        rr_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    state_d      = ADDR;
                    rr_adv       = !req[REQ_WB];
                    grant_d[win] = 1'b1;
                    reqcyc_d     = 1'b1;
                    req_d        = DATA_W'(line_align(win_addr));
                    tag_d        = req[REQ_WB] ? MEM_WRITE : MEM_READ;
                    beat_d       = '0;
                    wb_d         = wb_line;
                end
            end
            ADDR: begin
                if (bus.reqack) begin
                    if (grant_q[REQ_WB]) begin
                        state_d = WR_DATA;
                        req_d   = wb_q[0 +: DATA_W];
                    end else begin
                        state_d  = RD_WAIT;
                        reqcyc_d = 1'b0;
                    end
                end
            end
            WR_DATA: begin
                if (bus.reqack) begin
                    beat_d = beat_q + BW'(1);
                    if (last_beat) begin
                        state_d  = DONE;
                        reqcyc_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        req_d = wb_q[nxt_base +: DATA_W];
                    end
                end
            end
            RD_WAIT: begin
                if (bus.respcyc && bus.resptag == MEM_READ) begin
                    rd_line_d[cur_base +: DATA_W] = bus.resp;
                    beat_d    = beat_q + BW'(1);
                    respack_d = 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign rd_line     = rd_line_q;
    assign bus.reqcyc  = reqcyc_q;
    assign bus.req     = req_q;
    assign bus.reqtag  = tag_q;
    assign bus.respack = respack_q;
endmodule
